cam_write_buffer: RTL

CAM_WRITE_BUFFER -- requirements
Module: cam_write_buffer

---
 rtl/cam_write_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cam_write_buffer.sv
`default_nettype none
// cam_write_buffer: packs camera bytes into 16-bit words, queues them in a FIFO and
// writes each one to DRAM over a four-phase req/ack handshake.  Rev 1.0
module cam_write_buffer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [14:0] START_ADDR = 15'h0000
) (
  input  logic                          CLK100MHz,
  input  logic                          reset,
  input  logic                          frameStart,
  input  logic                          pixelValid,
  input  logic [7:0]                    pixelData,
  input  logic                          DRAMWriteAck,
  output logic                          DRAMWriteReq,
  output logic [12:0]                   rowAddress,
  output logic [1:0]                    bankAddress,
  output logic [15:0]                   dataToDRAM,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = FIFO_DEPTH[CW-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q;
  logic            req_q, ovf_q, phase_q, clr_pend_q, nonempty_q;
  logic [7:0]      hi_q;
  logic [15:0]     data_q;
  logic [14:0]     addr_q, out_addr_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic            in_flight, pop, word_done, push, drop;

  always_comb begin
    in_flight = (state_q == REQ) || (state_q == RELEASE);
    pop       = (state_q == RELEASE) && !DRAMWriteAck;
    word_done = pixelValid && phase_q && !frameStart;
    push      = word_done && ((count_q != C_DEPTH) || pop);
    drop      = word_done && !push;
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    wr_ptr_d  = wr_ptr_q + AW'(push);
    count_d   = count_q + CW'(push) - CW'(pop);
    // A frame restart keeps only the word currently being handed to DRAM.
    if (frameStart) begin
      if (in_flight) begin
        wr_ptr_d = rd_ptr_q + AW'(1);
        count_d  = pop ? '0 : CW'(1);
      end else begin
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (push) mem_q[wr_ptr_q] <= {hi_q, pixelData};
  end

  always_ff @(posedge CLK100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      out_addr_q <= '0;
      addr_q     <= START_ADDR;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      nonempty_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      nonempty_q <= (count_q != '0);
      if (frameStart) begin
        phase_q <= pixelValid;
        ovf_q   <= 1'b0;
      end else begin
        if (pixelValid) phase_q <= ~phase_q;
        if (drop)       ovf_q   <= 1'b1;
      end
      if (pixelValid && (frameStart || !phase_q)) hi_q <= pixelData;
      if (frameStart && in_flight && !pop) clr_pend_q <= 1'b1;
      if (frameStart && !in_flight) addr_q <= '0;
      // nonempty_q lags count_q by one edge, giving the two-edge push-to-req latency.
      case (state_q)
        IDLE: begin
          if (!frameStart && nonempty_q && (count_q != '0)) begin
            state_q    <= REQ;
            req_q      <= 1'b1;
            data_q     <= mem_q[rd_ptr_q];
            out_addr_q <= addr_q;
          end
        end
        REQ: begin
          if (DRAMWriteAck) begin
            state_q <= RELEASE;
            req_q   <= 1'b0;
          end
        end
        RELEASE: begin
          if (!DRAMWriteAck) begin
            state_q    <= IDLE;
            addr_q     <= (frameStart || clr_pend_q) ? 15'h0000 : addr_q + 15'h0001;
            clr_pend_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DRAMWriteReq = req_q;
  assign dataToDRAM   = data_q;
  assign rowAddress   = out_addr_q[12:0];
  assign bankAddress  = out_addr_q[14:13];
  assign fifoCount    = count_q;
  assign overflow     = ovf_q;
endmodule
`default_nettype wire
